ysyx_22040228_div_ctrl: RTL and testbench

- Sequencing controller for the iterative 64-bit divider in the EX stage.
- Accepts DIV/DIVU/REM/REMU and W-variant requests from EX and prepares the operands (32-bit extension for W ops).
- Resolves RISC-V special cases (divide-by-zero, signed overflow) without starting the divider.
- Otherwise starts the divider, waits for its finish pulse, and returns a final result with a one-cycle valid. It stalls the pipeline while busy and absorbs flushes, because a running divide cannot be aborted.

---
 rtl/ysyx_22040228_div_ctrl_pkg.sv | 40 ++++
 rtl/ysyx_22040228_div_ctrl_if.sv | 35 +++
 rtl/ysyx_22040228_div_special.sv | 59 +++++
 rtl/ysyx_22040228_div_ctrl.sv | 137 +++++++++++++
 tb/tb_ysyx_22040228_div_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040228_div_ctrl_pkg.sv
// Shared opcode encodings, controller state encodings and opcode decode
// helpers for the EX-stage divide sequencer.
package ysyx_22040228_div_ctrl_pkg;

    // Opcode reset value and the eight divide-class opcodes.
    localparam logic [7:0] INST_RST   = 8'h00;
    localparam logic [7:0] INST_DIV   = 8'h30;
    localparam logic [7:0] INST_DIVU  = 8'h31;
    localparam logic [7:0] INST_REM   = 8'h32;
    localparam logic [7:0] INST_REMU  = 8'h33;
    localparam logic [7:0] INST_DIVW  = 8'h34;
    localparam logic [7:0] INST_DIVUW = 8'h35;
    localparam logic [7:0] INST_REMW  = 8'h36;
    localparam logic [7:0] INST_REMUW = 8'h37;

    // One-hot controller states.
    localparam logic [4:0] ysyx22040228_DCTL_IDLE  = 5'b00001;
    localparam logic [4:0] ysyx22040228_DCTL_START = 5'b00010;
    localparam logic [4:0] ysyx22040228_DCTL_WAIT  = 5'b00100;
    localparam logic [4:0] ysyx22040228_DCTL_DONE  = 5'b01000;
    localparam logic [4:0] ysyx22040228_DCTL_DRAIN = 5'b10000;

    function automatic logic op_is_div(input logic [7:0] op);
        return op inside {INST_DIV, INST_DIVU, INST_REM, INST_REMU,
                          INST_DIVW, INST_DIVUW, INST_REMW, INST_REMUW};
    endfunction

    function automatic logic op_is_w(input logic [7:0] op);
        return op inside {INST_DIVW, INST_DIVUW, INST_REMW, INST_REMUW};
    endfunction

    function automatic logic op_is_signed(input logic [7:0] op);
        return op inside {INST_DIV, INST_REM, INST_DIVW, INST_REMW};
    endfunction

    function automatic logic op_is_rem(input logic [7:0] op);
        return op inside {INST_REM, INST_REMU, INST_REMW, INST_REMUW};
    endfunction

endpackage

// File: rtl/ysyx_22040228_div_ctrl_if.sv
// EX-side request/response and divider-side handshake bundle.
// master = EX stage plus divider, slave = the divide controller.
interface ysyx_22040228_div_ctrl_if #(
    parameter int unsigned XLEN = 64
);
    logic            req_valid;
    logic [7:0]      req_opcode;
    logic [XLEN-1:0] req_src1;
    logic [XLEN-1:0] req_src2;
    logic            flush;
    logic            busy;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;
    logic            resp_err;
    logic            div_ready;
    logic [XLEN-1:0] div_dividend;
    logic [XLEN-1:0] div_diviser;
    logic [7:0]      div_opcode;
    logic [XLEN-1:0] div_rem_data;
    logic            div_finish;

    modport master (
        output req_valid, req_opcode, req_src1, req_src2, flush,
               div_rem_data, div_finish,
        input  busy, resp_valid, resp_data, resp_err,
               div_ready, div_dividend, div_diviser, div_opcode
    );

    modport slave (
        input  req_valid, req_opcode, req_src1, req_src2, flush,
               div_rem_data, div_finish,
        output busy, resp_valid, resp_data, resp_err,
               div_ready, div_dividend, div_diviser, div_opcode
    );
endinterface

// File: rtl/ysyx_22040228_div_special.sv
// Operand extension for W ops plus RISC-V divide-by-zero / signed-overflow
// detection and the architectural result for those cases.
module ysyx_22040228_div_special
    import ysyx_22040228_div_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [7:0]      opcode,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            is_div,
    output logic            is_special,
    output logic [XLEN-1:0] dividend,
    output logic [XLEN-1:0] diviser,
    output logic [XLEN-1:0] result
);
    localparam int unsigned HW = XLEN / 2;

    logic            w_op;
    logic            s_op;
    logic            r_op;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] min_neg;

    // Extend operands, then classify against the extended values.
    always_comb begin
        w_op   = op_is_w(opcode);
        s_op   = op_is_signed(opcode);
        r_op   = op_is_rem(opcode);
        is_div = op_is_div(opcode);

        dividend = src1;
        diviser  = src2;
        min_neg  = {1'b1, {(XLEN-1){1'b0}}};
        if (w_op) begin
            if (s_op) begin
                dividend = {{(XLEN-HW){src1[HW-1]}}, src1[HW-1:0]};
                diviser  = {{(XLEN-HW){src2[HW-1]}}, src2[HW-1:0]};
            end else begin
                dividend = {{(XLEN-HW){1'b0}}, src1[HW-1:0]};
                diviser  = {{(XLEN-HW){1'b0}}, src2[HW-1:0]};
            end
            // Most-negative 32-bit value as it appears after sign extension.
            min_neg = {{(XLEN-HW+1){1'b1}}, {(HW-1){1'b0}}};
        end

        div_zero   = (diviser == '0);
        overflow   = s_op && (dividend == min_neg) && (diviser == '1);
        is_special = is_div && (div_zero || overflow);

        result = '0;
        if (div_zero) begin
            result = r_op ? dividend : '1;
        end else if (overflow) begin
            result = r_op ? '0 : dividend;
        end
    end
endmodule

// File: rtl/ysyx_22040228_div_ctrl.sv
// Sequencing controller for the iterative divider: accepts divide-class
// requests, short-circuits special cases, runs the divider, stalls EX while
// busy and swallows flushes because a running divide cannot be aborted.
module ysyx_22040228_div_ctrl
    import ysyx_22040228_div_ctrl_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned WDOG_CYCLES = 80
) (
    input logic                       clk,
    input logic                       rst,
    ysyx_22040228_div_ctrl_if.slave   bus
);
    localparam int unsigned HW  = XLEN / 2;
    localparam int unsigned WDW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);

    logic [4:0]      state;
    logic [4:0]      state_nxt;
    logic [WDW-1:0]  wdog_cnt;
    logic [XLEN-1:0] dividend_q;
    logic [XLEN-1:0] diviser_q;
    logic [XLEN-1:0] result_q;
    logic [7:0]      opcode_q;
    logic            err_q;
    logic            accept;
    logic            resp_valid;

    logic            sp_is_div;
    logic            sp_is_special;
    logic [XLEN-1:0] sp_dividend;
    logic [XLEN-1:0] sp_diviser;
    logic [XLEN-1:0] sp_result;

    ysyx_22040228_div_special #(
        .XLEN(XLEN)
    ) u_special (
        .opcode     (bus.req_opcode),
        .src1       (bus.req_src1),
        .src2       (bus.req_src2),
        .is_div     (sp_is_div),
        .is_special (sp_is_special),
        .dividend   (sp_dividend),
        .diviser    (sp_diviser),
        .result     (sp_result)
    );

    // W-op results are the sign extension of the low half.
    function automatic logic [XLEN-1:0] fix_w(input logic [7:0] op,
                                              input logic [XLEN-1:0] v);
        return op_is_w(op) ? {{(XLEN-HW){v[HW-1]}}, v[HW-1:0]} : v;
    endfunction

    assign accept = (state == ysyx22040228_DCTL_IDLE) && bus.req_valid &&
                    !bus.flush && sp_is_div;

    // Next-state selection, including flush absorption.
    always_comb begin
        state_nxt = state;
        case (state)
            ysyx22040228_DCTL_IDLE:
                if (accept)
                    state_nxt = sp_is_special ? ysyx22040228_DCTL_DONE
                                              : ysyx22040228_DCTL_START;
            ysyx22040228_DCTL_START:
                state_nxt = bus.flush ? ysyx22040228_DCTL_DRAIN
                                      : ysyx22040228_DCTL_WAIT;
            ysyx22040228_DCTL_WAIT:
                if (bus.div_finish)
                    state_nxt = bus.flush ? ysyx22040228_DCTL_IDLE
                                          : ysyx22040228_DCTL_DONE;
                else if (bus.flush)
                    state_nxt = ysyx22040228_DCTL_DRAIN;
                else if (wdog_cnt == WDOG_LAST)
                    state_nxt = ysyx22040228_DCTL_DONE;
            ysyx22040228_DCTL_DONE:
                state_nxt = ysyx22040228_DCTL_IDLE;
            ysyx22040228_DCTL_DRAIN:
                if (bus.div_finish)
                    state_nxt = ysyx22040228_DCTL_IDLE;
            default:
                state_nxt = ysyx22040228_DCTL_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ysyx22040228_DCTL_IDLE;
        else     state <= state_nxt;
    end

    // Operand latch, watchdog and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q   <= INST_RST;
            dividend_q <= '0;
            diviser_q  <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            wdog_cnt   <= '0;
        end else begin
            case (state)
                ysyx22040228_DCTL_IDLE:
                    if (accept) begin
                        opcode_q   <= bus.req_opcode;
                        dividend_q <= sp_dividend;
                        diviser_q  <= sp_diviser;
                        err_q      <= 1'b0;
                        result_q   <= fix_w(bus.req_opcode, sp_result);
                    end
                ysyx22040228_DCTL_START:
                    wdog_cnt <= '0;
                ysyx22040228_DCTL_WAIT: begin
                    wdog_cnt <= wdog_cnt + WDW'(1);
                    if (bus.div_finish) begin
                        result_q <= fix_w(opcode_q, bus.div_rem_data);
                        err_q    <= 1'b0;
                    end else if (!bus.flush && wdog_cnt == WDOG_LAST) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_valid       = (state == ysyx22040228_DCTL_DONE) && !bus.flush;
    assign bus.resp_valid   = resp_valid;
    assign bus.resp_err     = resp_valid && err_q;
    assign bus.resp_data    = resp_valid ? result_q : '0;
    assign bus.busy         = (state != ysyx22040228_DCTL_IDLE) || accept;
    assign bus.div_ready    = (state == ysyx22040228_DCTL_START);
    assign bus.div_dividend = dividend_q;
    assign bus.div_diviser  = diviser_q;
    assign bus.div_opcode   = opcode_q;
endmodule

// File: tb/tb_ysyx_22040228_div_ctrl.sv
// Self-checking bench for the divide controller; the bench also plays the
// role of the EX stage and of a behavioural divider.
module tb_ysyx_22040228_div_ctrl;
    import ysyx_22040228_div_ctrl_pkg::*;

    localparam int WDOG = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ysyx_22040228_div_ctrl_if #(.XLEN(64)) bus ();

    ysyx_22040228_div_ctrl #(
        .XLEN        (64),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (RISC-V M-extension rules) ----------
    function automatic bit is_w(input logic [7:0] op);
        return op == INST_DIVW || op == INST_DIVUW || op == INST_REMW || op == INST_REMUW;
    endfunction
    function automatic bit is_s(input logic [7:0] op);
        return op == INST_DIV || op == INST_REM || op == INST_DIVW || op == INST_REMW;
    endfunction
    function automatic bit is_r(input logic [7:0] op);
        return op == INST_REM || op == INST_REMU || op == INST_REMW || op == INST_REMUW;
    endfunction

    // What the divider must be handed.
    function automatic logic [63:0] ref_ext(input logic [7:0] op, input logic [63:0] v);
        if (!is_w(op)) return v;
        return is_s(op) ? {{32{v[31]}}, v[31:0]} : {32'h0, v[31:0]};
    endfunction

    function automatic bit ref_special(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
        if (is_w(op))
            return b[31:0] == 32'h0 ||
                   (is_s(op) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return b == 64'h0 ||
               (is_s(op) && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    endfunction

    function automatic logic [63:0] ref_result(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [31:0] x, y, q32, m32, r32;
        logic [63:0] q64, m64;
        if (is_w(op)) begin
            x = a[31:0];
            y = b[31:0];
            if (y == 0) begin q32 = '1; m32 = x; end
            else if (is_s(op) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin q32 = x; m32 = 0; end
            else if (is_s(op)) begin q32 = $signed(x) / $signed(y); m32 = $signed(x) % $signed(y); end
            else begin q32 = x / y; m32 = x % y; end
            r32 = is_r(op) ? m32 : q32;
            return {{32{r32[31]}}, r32};
        end
        if (b == 0) begin q64 = '1; m64 = a; end
        else if (is_s(op) && a == 64'h8000_0000_0000_0000 && b == '1) begin q64 = a; m64 = 0; end
        else if (is_s(op)) begin q64 = $signed(a) / $signed(b); m64 = $signed(a) % $signed(b); end
        else begin q64 = a / b; m64 = a % b; end
        return is_r(op) ? m64 : q64;
    endfunction

    // One complete request. lat = cycles from div_ready to div_finish;
    // lat <= 0 models a hung divider. Called at #1 after a rising edge.
    task automatic do_op(input string tag, input logic [7:0] op, input logic [63:0] a,
                         input logic [63:0] b, input int lat);
        bit          sp   = ref_special(op, a, b);
        logic [63:0] exp  = ref_result(op, a, b);
        logic [63:0] raw  = is_w(op) ? {$urandom, exp[31:0]} : exp;
        bit          hang = (lat <= 0);
        int cyc = 0, rdy_cyc = -1, resp_cyc = -1, nrdy = 0, nresp = 0, exp_cyc;
        bit busy_ok = 1'b1;
        logic [63:0] data_obs = '0;
        logic        err_obs  = 1'b0;

        bus.req_valid  = 1'b1;
        bus.req_opcode = op;
        bus.req_src1   = a;
        bus.req_src2   = b;
        bus.flush      = 1'b0;
        #1;
        check({tag, "_busy_req"}, 64'(bus.busy), 64'd1);
        while (cyc < 200 && !(resp_cyc >= 0 && cyc >= resp_cyc + 2)) begin
            @(posedge clk); #1;
            cyc++;
            if (!hang && rdy_cyc >= 0 && cyc == rdy_cyc + lat) begin
                bus.div_finish   = 1'b1;
                bus.div_rem_data = raw;
            end else begin
                bus.div_finish   = 1'b0;
                bus.div_rem_data = {$urandom, $urandom};
            end
            #1;
            if (bus.div_ready) begin
                nrdy++;
                rdy_cyc = cyc;
                check({tag, "_div_dividend"}, bus.div_dividend, ref_ext(op, a));
                check({tag, "_div_diviser"},  bus.div_diviser,  ref_ext(op, b));
                check({tag, "_div_opcode"},   64'(bus.div_opcode), 64'(op));
            end
            if (bus.resp_valid) begin
                nresp++;
                if (resp_cyc < 0) begin
                    resp_cyc = cyc;
                    data_obs = bus.resp_data;
                    err_obs  = bus.resp_err;
                end
                bus.req_valid = 1'b0;
            end
            if ((resp_cyc < 0 || resp_cyc == cyc) && !bus.busy) busy_ok = 1'b0;
        end
        bus.div_finish = 1'b0;
        check({tag, "_resp_count"}, 64'(nresp), 64'd1);
        check({tag, "_ready_count"}, 64'(nrdy), sp ? 64'd0 : 64'd1);
        check({tag, "_busy_hold"}, 64'(busy_ok), 64'd1);
        check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
        if (hang) begin
            // START cycle followed by WDOG WAIT cycles, then the DONE cycle.
            exp_cyc = rdy_cyc + WDOG + 1;
            check({tag, "_data"}, data_obs, 64'h0);
            check({tag, "_err"}, 64'(err_obs), 64'd1);
        end else begin
            exp_cyc = sp ? 1 : rdy_cyc + lat + 1;
            check({tag, "_data"}, data_obs, exp);
            check({tag, "_err"}, 64'(err_obs), 64'd0);
        end
        check({tag, "_latency"}, 64'(resp_cyc), 64'(exp_cyc));
    endtask

    logic [7:0] ops [8];
    int         hits;
    logic [7:0]  rop;
    logic [63:0] ra, rb;

    initial begin
        ops = '{INST_DIV, INST_DIVU, INST_REM, INST_REMU,
                INST_DIVW, INST_DIVUW, INST_REMW, INST_REMUW};
        bus.req_valid = 0; bus.req_opcode = 0; bus.req_src1 = 0; bus.req_src2 = 0;
        bus.flush = 0; bus.div_finish = 0; bus.div_rem_data = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", {60'h0, bus.busy, bus.resp_valid, bus.resp_err, bus.div_ready}, 64'h0);
        check("reset_data", bus.resp_data | bus.div_dividend | bus.div_diviser, 64'h0);
        check("reset_opcode", 64'(bus.div_opcode), 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        do_op("div_100_m7", INST_DIV, 64'd100, -64'sd7, 67);
        do_op("remu_by0", INST_REMU, 64'd5, 64'd0, 5);
        do_op("div_ovf", INST_DIV, 64'h8000_0000_0000_0000, '1, 5);
        do_op("remw_ovf", INST_REMW, 64'h8000_0000, 64'hFFFF_FFFF, 5);
        do_op("divuw", INST_DIVUW, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 10);
        do_op("remuw_by0", INST_REMUW, 64'h1234_5678_8000_0001, 64'hFFFF_FFFF_0000_0000, 3);

        // Randomized mix, including forced special operands
        for (int i = 0; i < 24; i++) begin
            rop = ops[$urandom_range(0, 7)];
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: rb = is_w(rop) ? {$urandom, 32'h0} : 64'h0;
                1: begin
                    ra = is_w(rop) ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    rb = is_w(rop) ? {$urandom, 32'hFFFF_FFFF} : '1;
                end
                2: rb = {56'h0, 8'($urandom)};
                default: ;
            endcase
            do_op("rand", rop, ra, rb, $urandom_range(1, 20));
        end

        // Hung divider: watchdog response
        do_op("wdog", INST_DIVU, 64'd1000, 64'd7, 0);

        // Flush 10 cycles into WAIT, new request held through DRAIN
        bus.req_valid = 1; bus.req_opcode = INST_DIV; bus.req_src1 = 64'd1000; bus.req_src2 = 64'd3;
        @(posedge clk); #2;
        check("fw_start_ready", 64'(bus.div_ready), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1; bus.req_opcode = INST_REMU; bus.req_src1 = 64'd5; bus.req_src2 = 64'd0;
        #1;
        check("fw_flush_no_resp", 64'(bus.resp_valid), 64'd0);
        @(posedge clk); #1;
        bus.flush = 0;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.resp_valid || bus.div_ready || !bus.busy) hits++;
            @(posedge clk); #1;
        end
        check("fw_drain_quiet", 64'(hits), 64'd0);
        bus.div_finish = 1; bus.div_rem_data = 64'hDEAD_BEEF;
        #1;
        check("fw_drain_finish_no_resp", 64'(bus.resp_valid), 64'd0);
        @(posedge clk); #1;
        bus.div_finish = 0;
        #1;
        check("fw_idle_accept_busy", 64'(bus.busy), 64'd1);
        check("fw_idle_no_resp", 64'(bus.resp_valid), 64'd0);
        @(posedge clk); #2;
        check("fw_resp_valid", 64'(bus.resp_valid), 64'd1);
        check("fw_resp_data", bus.resp_data, 64'd5);
        bus.req_valid = 0;
        @(posedge clk); #2;
        check("fw_idle_after", 64'(bus.busy), 64'd0);

        // Flush in START: div_ready still issued, result later discarded
        bus.req_valid = 1; bus.req_opcode = INST_DIVU; bus.req_src1 = 64'd77; bus.req_src2 = 64'd7;
        @(posedge clk); #1;
        bus.flush = 1; bus.req_valid = 0;
        #1;
        check("fs_ready", 64'(bus.div_ready), 64'd1);
        @(posedge clk); #1;
        bus.flush = 0;
        #1;
        check("fs_drain_busy", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        bus.div_finish = 1;
        #1;
        check("fs_finish_no_resp", 64'(bus.resp_valid), 64'd0);
        @(posedge clk); #1;
        bus.div_finish = 0;
        #1;
        check("fs_idle", {62'h0, bus.busy, bus.resp_valid}, 64'h0);

        // Flush in DONE suppresses the response
        bus.req_valid = 1; bus.req_opcode = INST_REMU; bus.req_src1 = 64'd5; bus.req_src2 = 64'd0;
        @(posedge clk); #1;
        bus.flush = 1; bus.req_valid = 0;
        #1;
        check("fd_no_resp", 64'(bus.resp_valid), 64'd0);
        @(posedge clk); #1;
        bus.flush = 0;
        #1;
        check("fd_idle", {62'h0, bus.busy, bus.resp_valid}, 64'h0);

        // Flush in IDLE: request not accepted
        bus.req_valid = 1; bus.req_opcode = INST_DIV; bus.flush = 1;
        #1;
        check("fi_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        bus.req_valid = 0; bus.flush = 0;
        #1;
        check("fi_no_start", {62'h0, bus.div_ready, bus.busy}, 64'h0);

        // Non-divide opcode is ignored
        bus.req_valid = 1; bus.req_opcode = 8'h13;
        #1;
        check("nd_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #2;
        check("nd_idle", {62'h0, bus.div_ready, bus.busy}, 64'h0);
        bus.req_valid = 0;

        // Reset asserted in WAIT
        bus.req_valid = 1; bus.req_opcode = INST_DIV; bus.req_src1 = 64'd99; bus.req_src2 = 64'd4;
        repeat (4) @(posedge clk);
        #1;
        bus.req_valid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        #1;
        check("rw_ctrl", {60'h0, bus.busy, bus.resp_valid, bus.resp_err, bus.div_ready}, 64'h0);
        check("rw_data", bus.resp_data | bus.div_dividend | bus.div_diviser, 64'h0);
        check("rw_opcode", 64'(bus.div_opcode), 64'h0);
        bus.div_finish = 1;
        @(posedge clk); #1;
        bus.div_finish = 0;
        #1;
        check("rw_finish_ignored", {62'h0, bus.busy, bus.resp_valid}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
